sha2_compress_iter: RTL and testbench

- Iterative SHA-2 compression engine that processes one 512/1024-bit message block per request.
- Executes one round per clock and generates the message schedule on the fly.
- Applies the final feed-forward addition to the chaining value.
- Sits between the message padder/block buffer and the digest register; one instance serves SHA-256 (WORDSIZE=32) or SHA-512 (WORDSIZE=64).

---
 rtl/sha2_pkg.sv | 56 +++++
 rtl/sha2_compress_iter_if.sv | 17 +
 rtl/sha2_msg_schedule.sv | 47 ++++
 rtl/sha2_compress_iter.sv | 138 +++++++++++++
 tb/tb_sha2_compress_iter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha2_pkg.sv
// SHA-2 constants, IVs, rotation amounts and FSM state shared by the compression engine.
// Constants are laid out so word 0 / H0 sit at the MSB end of packed buses.
package sha2_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINAL, ST_DONE} sha2_state_e;

  // ls* = lower-case sigma (schedule), us* = upper-case Sigma (round)
  typedef struct packed {
    int unsigned ls0_r1, ls0_r2, ls0_sh;
    int unsigned ls1_r1, ls1_r2, ls1_sh;
    int unsigned us0_r1, us0_r2, us0_r3;
    int unsigned us1_r1, us1_r2, us1_r3;
  } rot_t;

  localparam rot_t ROT256 = '{7, 18, 3, 17, 19, 10, 2, 13, 22, 6, 11, 25};
  localparam rot_t ROT512 = '{1, 8, 7, 19, 61, 6, 28, 34, 39, 14, 18, 41};

  localparam logic [255:0] IV256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] IV512 =
    {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
     64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

endpackage

// File: rtl/sha2_compress_iter_if.sv
// Request/result bundle of the iterative SHA-2 compression engine.
// master = block source / digest sink, slave = engine.
interface sha2_compress_iter_if #(parameter int WORDSIZE = 32);
  logic                    in_valid;
  logic                    in_ready;
  logic [16*WORDSIZE-1:0]  block_in;
  logic [8*WORDSIZE-1:0]   hash_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [8*WORDSIZE-1:0]   hash_out;
  logic                    busy;

  modport master (output in_valid, block_in, hash_in, out_ready,
                  input  in_ready, out_valid, hash_out, busy);
  modport slave  (input  in_valid, block_in, hash_in, out_ready,
                  output in_ready, out_valid, hash_out, busy);
endinterface

// File: rtl/sha2_msg_schedule.sv
// 16-word sliding message schedule: head is W[t], tail is refilled with W[t+16] on each shift.
// Loads a whole block in one cycle; shifts only when the engine runs a round.
module sha2_msg_schedule
  import sha2_pkg::*;
#(
  parameter int WORDSIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   shift,
  input  logic [16*WORDSIZE-1:0] block_in,
  output logic [WORDSIZE-1:0]    w_out
);
  typedef logic [WORDSIZE-1:0] word_t;
  localparam rot_t ROT = (WORDSIZE == 64) ? ROT512 : ROT256;

  word_t win [16];
  word_t w_next;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORDSIZE - n));
  endfunction

  function automatic word_t sig0(input word_t x);
    return rotr(x, ROT.ls0_r1) ^ rotr(x, ROT.ls0_r2) ^ (x >> ROT.ls0_sh);
  endfunction

  function automatic word_t sig1(input word_t x);
    return rotr(x, ROT.ls1_r1) ^ rotr(x, ROT.ls1_r2) ^ (x >> ROT.ls1_sh);
  endfunction

  // win[i] holds W[t+i], so W[t+16] draws on taps 14, 9, 1 and 0
  assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  assign w_out  = win[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block_in[(15-i)*WORDSIZE +: WORDSIZE];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_next;
    end
  end
endmodule

// File: rtl/sha2_compress_iter.sv
// Iterative SHA-2 compression: one round per clock, result NUM_ROUNDS+1 cycles after acceptance.
// Accepts only in IDLE; DONE holds hash_out/out_valid until out_ready.
module sha2_compress_iter
  import sha2_pkg::*;
#(
  parameter int WORDSIZE   = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sha2_compress_iter_if.slave  bus
);
  typedef logic [WORDSIZE-1:0] word_t;
  localparam rot_t       ROT    = (WORDSIZE == 64) ? ROT512 : ROT256;
  localparam logic [6:0] LAST_T = 7'(NUM_ROUNDS - 1);

  if (!((WORDSIZE == 32 && NUM_ROUNDS == 64) || (WORDSIZE == 64 && NUM_ROUNDS == 80))) begin : g_bad_cfg
    $error("sha2_compress_iter: WORDSIZE/NUM_ROUNDS must be 32/64 or 64/80");
  end

  sha2_state_e             state_q, state_d;
  logic        [6:0]       t_q;
  word_t                   work_q   [8];
  word_t                   h_save_q [8];
  logic [8*WORDSIZE-1:0]   hash_q;
  word_t                   w_t, k_t, t1, t2;
  logic                    do_load, do_round, do_final;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORDSIZE - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, ROT.us0_r1) ^ rotr(x, ROT.us0_r2) ^ rotr(x, ROT.us0_r3);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, ROT.us1_r1) ^ rotr(x, ROT.us1_r2) ^ rotr(x, ROT.us1_r3);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  if (WORDSIZE == 64) begin : g_k512
    assign k_t = K512[t_q];
  end else begin : g_k256
    assign k_t = K256[t_q[5:0]];
  end

  sha2_msg_schedule #(.WORDSIZE(WORDSIZE)) u_sched (
    .clk      (clk),
    .rst      (rst),
    .load     (do_load),
    .shift    (do_round),
    .block_in (bus.block_in),
    .w_out    (w_t)
  );

  // work_q[0..7] = a..h
  assign t1 = work_q[7] + big_sigma1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6]) + k_t + w_t;
  assign t2 = big_sigma0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    do_load  = 1'b0;
    do_round = 1'b0;
    do_final = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          do_load = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        do_round = 1'b1;
        if (t_q == LAST_T) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        do_final = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q    <= '0;
      hash_q <= '0;
      for (int i = 0; i < 8; i++) begin
        work_q[i]   <= '0;
        h_save_q[i] <= '0;
      end
    end else begin
      if (do_load) begin
        t_q <= '0;
        for (int i = 0; i < 8; i++) begin
          work_q[i]   <= bus.hash_in[(7-i)*WORDSIZE +: WORDSIZE];
          h_save_q[i] <= bus.hash_in[(7-i)*WORDSIZE +: WORDSIZE];
        end
      end
      if (do_round) begin
        if (t_q != LAST_T) t_q <= t_q + 7'd1;
        work_q[0] <= t1 + t2;
        work_q[1] <= work_q[0];
        work_q[2] <= work_q[1];
        work_q[3] <= work_q[2];
        work_q[4] <= work_q[3] + t1;
        work_q[5] <= work_q[4];
        work_q[6] <= work_q[5];
        work_q[7] <= work_q[6];
      end
      if (do_final) begin
        for (int i = 0; i < 8; i++) hash_q[(7-i)*WORDSIZE +: WORDSIZE] <= h_save_q[i] + work_q[i];
      end
    end
  end

  // rst gates in_ready so nothing looks acceptable while reset is held
  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_FINAL);
  assign bus.hash_out  = hash_q;
endmodule

// File: tb/tb_sha2_compress_iter.sv
// Bench for sha2_compress_iter: SHA-256 and SHA-512 instances against known digests and a FIPS-style model.
module tb_sha2_compress_iter;
  import sha2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sha2_compress_iter_if #(.WORDSIZE(32)) if256 ();
  sha2_compress_iter_if #(.WORDSIZE(64)) if512 ();

  sha2_compress_iter #(.WORDSIZE(32), .NUM_ROUNDS(64)) u256 (.clk(clk), .rst(rst), .bus(if256));
  sha2_compress_iter #(.WORDSIZE(64), .NUM_ROUNDS(80)) u512 (.clk(clk), .rst(rst), .bus(if512));

  localparam logic [511:0]  ABC_BLK   = {32'h61626380, 448'h0, 32'h18};
  localparam logic [511:0]  EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0]  ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0]  EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0]  TWO_BLK1  = {256'h6162636462636465636465666465666765666768666768696768696a68696a6b,
                                         256'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f707180000000_00000000};
  localparam logic [511:0]  TWO_BLK2  = {480'h0, 32'h1c0};
  localparam logic [255:0]  TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [1023:0] ABC512_BLK = {64'h6162638000000000, 896'h0, 64'h18};

  typedef struct {
    string        name;
    logic [511:0] blk;
    logic [255:0] hin;
    logic [255:0] exp;
  } vec_t;

  // ---------------- reference model (FIPS 180-4, whole-array form) ----------------
  function automatic logic [63:0] mmask(input int ws);
    return (ws == 64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
  endfunction

  function automatic logic [63:0] m_rotr(input int ws, input logic [63:0] x, input int n);
    return ((x >> n) | (x << (ws - n))) & mmask(ws);
  endfunction

  function automatic logic [63:0] m_lsig(input int ws, input int which, input logic [63:0] x);
    if (ws == 64)
      return (which == 1) ? (m_rotr(ws, x, 19) ^ m_rotr(ws, x, 61) ^ (x >> 6))
                          : (m_rotr(ws, x, 1)  ^ m_rotr(ws, x, 8)  ^ (x >> 7));
    return (which == 1) ? (m_rotr(ws, x, 17) ^ m_rotr(ws, x, 19) ^ (x >> 10))
                        : (m_rotr(ws, x, 7)  ^ m_rotr(ws, x, 18) ^ (x >> 3));
  endfunction

  function automatic logic [63:0] m_usig(input int ws, input int which, input logic [63:0] x);
    if (ws == 64)
      return (which == 1) ? (m_rotr(ws, x, 14) ^ m_rotr(ws, x, 18) ^ m_rotr(ws, x, 41))
                          : (m_rotr(ws, x, 28) ^ m_rotr(ws, x, 34) ^ m_rotr(ws, x, 39));
    return (which == 1) ? (m_rotr(ws, x, 6) ^ m_rotr(ws, x, 11) ^ m_rotr(ws, x, 25))
                        : (m_rotr(ws, x, 2) ^ m_rotr(ws, x, 13) ^ m_rotr(ws, x, 22));
  endfunction

  // Words live in 64-bit containers; SHA-256 uses the low 32 bits and the
  // upper halves of the SHA-512 round constants.
  function automatic logic [511:0] ref_compress(input int ws, input logic [1023:0] blk, input logic [511:0] hin);
    logic [63:0]  w [80];
    logic [63:0]  hv [8];
    logic [63:0]  v [8];
    logic [63:0]  t1, t2, kk, kt, s, m;
    logic [511:0] res;
    int           nr;
    m   = mmask(ws);
    nr  = (ws == 64) ? 80 : 64;
    res = '0;
    for (int i = 0; i < 16; i++)
      w[i] = (ws == 64) ? blk[(15-i)*64 +: 64] : {32'h0, blk[(15-i)*32 +: 32]};
    for (int i = 16; i < nr; i++)
      w[i] = (m_lsig(ws, 1, w[i-2]) + w[i-7] + m_lsig(ws, 0, w[i-15]) + w[i-16]) & m;
    for (int i = 0; i < 8; i++) begin
      hv[i] = (ws == 64) ? hin[(7-i)*64 +: 64] : {32'h0, hin[(7-i)*32 +: 32]};
      v[i]  = hv[i];
    end
    for (int i = 0; i < nr; i++) begin
      kt = K512[i];
      kk = (ws == 64) ? kt : (kt >> 32);
      t1 = (v[7] + m_usig(ws, 1, v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kk + w[i]) & m;
      t2 = (m_usig(ws, 0, v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]))) & m;
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4];
      v[4] = (v[3] + t1) & m;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0];
      v[0] = (t1 + t2) & m;
    end
    for (int i = 0; i < 8; i++) begin
      s = (hv[i] + v[i]) & m;
      if (ws == 64) res[(7-i)*64 +: 64] = s;
      else          res[(7-i)*32 +: 32] = s[31:0];
    end
    return res;
  endfunction

  function automatic logic [255:0] ref256(input logic [511:0] blk, input logic [255:0] hin);
    logic [511:0] r;
    r = ref_compress(32, {512'h0, blk}, {256'h0, hin});
    return r[255:0];
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, 512'(act), 512'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run256(input logic [511:0] blk, input logic [255:0] hin,
                        output logic [255:0] hout, output int lat);
    int n = 0;
    while (!if256.in_ready && n < 200) begin tick(); n++; end
    if256.block_in = blk;
    if256.hash_in  = hin;
    if256.in_valid = 1'b1;
    tick();
    if256.in_valid = 1'b0;
    lat = 0;
    while (!if256.out_valid && lat < 300) begin tick(); lat++; end
    hout = if256.hash_out;
    if256.out_ready = 1'b1;
    tick();
    if256.out_ready = 1'b0;
  endtask

  task automatic run512(input logic [1023:0] blk, input logic [511:0] hin,
                        output logic [511:0] hout, output int lat);
    int n = 0;
    while (!if512.in_ready && n < 200) begin tick(); n++; end
    if512.block_in = blk;
    if512.hash_in  = hin;
    if512.in_valid = 1'b1;
    tick();
    if512.in_valid = 1'b0;
    lat = 0;
    while (!if512.out_valid && lat < 300) begin tick(); lat++; end
    hout = if512.hash_out;
    if512.out_ready = 1'b1;
    tick();
    if512.out_ready = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t          vt [6];
    logic [255:0]  h256, h1;
    logic [511:0]  h512, hin512, r512;
    logic [1023:0] blk512;
    logic [511:0]  rblk;
    logic [255:0]  rhin;
    int            lat, n;

    if256.in_valid = 1'b0; if256.out_ready = 1'b0; if256.block_in = '0; if256.hash_in = '0;
    if512.in_valid = 1'b0; if512.out_ready = 1'b0; if512.block_in = '0; if512.hash_in = '0;

    vt[0] = '{"abc",   ABC_BLK,   IV256, ABC_DIG};
    vt[1] = '{"empty", EMPTY_BLK, IV256, EMPTY_DIG};
    for (int i = 2; i < 6; i++) begin
      rblk = '0; rhin = '0;
      for (int j = 0; j < 16; j++) rblk = {rblk[479:0], $urandom()};
      for (int j = 0; j < 8; j++)  rhin = {rhin[223:0], $urandom()};
      vt[i] = '{$sformatf("rand%0d", i), rblk, rhin, ref256(rblk, rhin)};
    end

    // reset state
    tick(); tick();
    chk1("rst_in_ready256", if256.in_ready, 1'b0);
    chk1("rst_out_valid256", if256.out_valid, 1'b0);
    chk1("rst_busy256", if256.busy, 1'b0);
    check("rst_hash256", 512'(if256.hash_out), '0);
    chk1("rst_in_ready512", if512.in_ready, 1'b0);
    chk1("rst_out_valid512", if512.out_valid, 1'b0);
    check("rst_hash512", if512.hash_out, '0);
    rst = 1'b0;
    tick();
    chk1("post_rst_in_ready256", if256.in_ready, 1'b1);
    chk1("post_rst_in_ready512", if512.in_ready, 1'b1);

    // table of SHA-256 vectors
    for (int i = 0; i < 6; i++) begin
      run256(vt[i].blk, vt[i].hin, h256, lat);
      check(vt[i].name, 512'(h256), 512'(vt[i].exp));
      check({vt[i].name, "_latency"}, 512'(lat), 512'(65));
    end

    // two-block message, chained through the model's first-block result
    h1 = ref256(TWO_BLK1, IV256);
    run256(TWO_BLK1, IV256, h256, lat);
    check("two_blk1", 512'(h256), 512'(h1));
    run256(TWO_BLK2, h1, h256, lat);
    check("two_blk2", 512'(h256), 512'(TWO_DIG));

    // SHA-512
    run512(ABC512_BLK, IV512, h512, lat);
    check("abc512_model", h512, ref_compress(64, ABC512_BLK, IV512));
    check("abc512_h0", 512'(h512[511:448]), 512'(64'hddaf35a193617aba));
    check("abc512_h7lo", 512'(h512[31:0]), 512'(32'ha54ca49f));
    check("abc512_latency", 512'(lat), 512'(81));
    for (int k = 0; k < 2; k++) begin
      blk512 = '0; hin512 = '0;
      for (int j = 0; j < 32; j++) blk512 = {blk512[991:0], $urandom()};
      for (int j = 0; j < 16; j++) hin512 = {hin512[479:0], $urandom()};
      r512 = ref_compress(64, blk512, hin512);
      run512(blk512, hin512, h512, lat);
      check($sformatf("rand512_%0d", k), h512, r512);
      check($sformatf("rand512_%0d_latency", k), 512'(lat), 512'(81));
    end

    // backpressure in DONE with a held request
    if256.block_in = ABC_BLK; if256.hash_in = IV256; if256.in_valid = 1'b1;
    tick();
    if256.in_valid = 1'b0;
    n = 0;
    while (!if256.out_valid && n < 300) begin tick(); n++; end
    if256.block_in = EMPTY_BLK; if256.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp_hash_c%0d", c), 512'(if256.hash_out), 512'(ABC_DIG));
      chk1($sformatf("bp_in_ready_c%0d", c), if256.in_ready, 1'b0);
      chk1($sformatf("bp_out_valid_c%0d", c), if256.out_valid, 1'b1);
      chk1($sformatf("bp_busy_c%0d", c), if256.busy, 1'b0);
      tick();
    end
    if256.out_ready = 1'b1;
    tick();
    if256.out_ready = 1'b0;
    chk1("bp_release_in_ready", if256.in_ready, 1'b1);
    chk1("bp_release_out_valid", if256.out_valid, 1'b0);
    check("bp_idle_hash_retained", 512'(if256.hash_out), 512'(ABC_DIG));
    tick();
    if256.in_valid = 1'b0;
    chk1("bp_held_req_accepted", if256.busy, 1'b1);
    n = 0;
    while (!if256.out_valid && n < 300) begin tick(); n++; end
    check("bp_held_req_hash", 512'(if256.hash_out), 512'(EMPTY_DIG));
    if256.out_ready = 1'b1;
    tick();
    if256.out_ready = 1'b0;

    // reset at round 30, then rerun "abc"
    if256.block_in = ABC_BLK; if256.hash_in = IV256; if256.in_valid = 1'b1;
    tick();
    if256.in_valid = 1'b0;
    repeat (30) tick();
    chk1("midrst_busy_before", if256.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("midrst_out_valid", if256.out_valid, 1'b0);
    chk1("midrst_busy", if256.busy, 1'b0);
    chk1("midrst_in_ready", if256.in_ready, 1'b0);
    check("midrst_hash", 512'(if256.hash_out), '0);
    tick();
    rst = 1'b0;
    tick();
    run256(ABC_BLK, IV256, h256, lat);
    check("midrst_rerun_abc", 512'(h256), 512'(ABC_DIG));
    check("midrst_rerun_latency", 512'(lat), 512'(65));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
